neopixel_pattern_gen: RTL

NEOPIXEL_PATTERN_GEN -- requirements
Module: neopixel_pattern_gen

---
 rtl/neopixel_pattern_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/neopixel_pattern_gen.sv
// Animation frame generator for a memory-mapped neopixel driver.
// Each frame writes every pixel colour, then a commit word.
module neopixel_pattern_gen #(
  parameter int          C_PIXELS = 12,
  parameter logic [31:0] C_RATE   = 32'd4166666
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] color,
  input  logic        ctrl_ready,
  output logic        ctrl_write,
  output logic [31:0] ctrl_address,
  output logic [31:0] ctrl_write_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE, WAIT_TICK, WRITE, COMMIT
  } state_t;

  localparam logic [7:0]  LAST   = 8'(C_PIXELS - 1);
  localparam logic [7:0]  NPIX   = 8'(C_PIXELS);
  localparam logic [31:0] RELOAD = C_RATE - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] color_q, color_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        strobe;

  function automatic logic [31:0] pix(
    input logic [1:0]  m,
    input logic [23:0] c,
    input logic [7:0]  i,
    input logic [7:0]  p
  );
    logic lit;
    case (m)
      2'd0:    lit = 1'b1;
      2'd1:    lit = (i == p);
      2'd2:    lit = (i <= p);
      default: lit = 1'b0;
    endcase
    return lit ? {8'h00, c} : 32'h0;
  endfunction

  // Strobe is gated combinationally so it never fires on a stalled cycle
  assign strobe          = busy_q & ctrl_ready;
  assign ctrl_write      = strobe;
  assign ctrl_address    = {24'h0, addr_q};
  assign ctrl_write_data = data_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    color_d = color_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_TICK;
          cnt_d   = RELOAD;
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == 32'd0) begin
          state_d = WRITE;
          mode_d  = mode;
          color_d = color;
          idx_d   = 8'd0;
          addr_d  = 8'd0;
          data_d  = pix(mode, color, 8'd0, pos_q);
          busy_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      WRITE: begin
        if (strobe) begin
          if (idx_q == LAST) begin
            state_d = COMMIT;
            addr_d  = NPIX;
            data_d  = 32'h1;
          end else begin
            idx_d  = idx_q + 8'd1;
            addr_d = idx_q + 8'd1;
            data_d = pix(mode_q, color_q, idx_q + 8'd1, pos_q);
          end
        end
      end
      COMMIT: begin
        if (strobe) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = RELOAD;
          pos_d   = (pos_q == LAST) ? 8'd0 : pos_q + 8'd1;
          state_d = enable ? WAIT_TICK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= RELOAD;
      pos_q   <= 8'd0;
      idx_q   <= 8'd0;
      mode_q  <= 2'd0;
      color_q <= 24'h0;
      addr_q  <= 8'd0;
      data_q  <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
